// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the LSB-first serializer.
// Optional feature macro: SERIAL_TX_PARITY_EN appends an even-parity bit to every frame.
package serial_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Bit-index counter width; always wide enough for the parity slot at index n.
  function automatic int unsigned cw_of(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bit periods per frame for an n-bit data word.
  function automatic int unsigned frame_len(input int unsigned n);
    return n + PARITY_BITS;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// N-bit parallel-load, right-shift register (MSB filled with 0).
// Ports: clk, reset (sync, active-high), load_i (priority over shift_i),
//        shift_i, d_i (parallel word), lsb_o (current bit 0).
module piso_shift_reg #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [N-1:0] d_i,
  output logic         lsb_o
);

  logic [N-1:0] q_q, q_d;

  // Next-value select: load wins over shift.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (shift_i) begin
      q_d = {1'b0, q_q[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign lsb_o = q_q[0];

endmodule

// File: rtl/serial_tx_shift_ctrl.sv
// Valid/ready-fed LSB-first serializer controller paced by bit_tick.
// Optional feature macro: SERIAL_TX_PARITY_EN (even parity bit at bit_idx = N).
// Ports: clk, reset (sync, active-high); in_data/in_valid/in_ready word handshake;
//        bit_tick shift enable; so/so_valid serial bit; busy frame in progress;
//        done one-cycle end-of-frame pulse; bit_idx index of bit on so.
module serial_tx_shift_ctrl
  import serial_tx_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned CW = cw_of(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          bit_tick,
  output logic          so,
  output logic          so_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] bit_idx
);

  localparam int unsigned LAST = frame_len(N) - 1;

  state_e        state_q, state_d;
  logic [CW-1:0] bit_idx_q, bit_idx_d;
  logic          done_q, done_d;
  logic          load, shift;
  logic          sr_lsb;
  logic          last_bit;
  logic          ser_bit;

  piso_shift_reg #(.N(N)) u_sr (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .shift_i (shift),
    .d_i     (in_data),
    .lsb_o   (sr_lsb)
  );

  assign last_bit = (bit_idx_q == CW'(LAST));

  // Only input-to-output combinational path: ready opens on the last-bit tick.
  assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && last_bit && bit_tick);

`ifdef SERIAL_TX_PARITY_EN
  logic par_q;

  // Parity captured at accept so the data register can keep shifting freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= ^in_data;
    end
  end

  assign ser_bit = (bit_idx_q == CW'(N)) ? par_q : sr_lsb;
`else
  assign ser_bit = sr_lsb;
`endif

  // Next-state, counter and register control.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          state_d   = SHIFT;
          bit_idx_d = '0;
        end
      end
      SHIFT: begin
        if (bit_tick) begin
          if (last_bit) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            if (in_valid) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift     = 1'b1;
            bit_idx_d = bit_idx_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
    end
  end

  assign so       = (state_q == SHIFT) & ser_bit;
  assign so_valid = (state_q == SHIFT);
  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bit_idx  = bit_idx_q;

endmodule

// File: doc/serial_tx_shift_ctrl.md
Name: serial_tx_shift_ctrl

Overview:
Controller that sequences an N-bit parallel-load / right-shift register as a LSB-first serializer.
- Accepts words over a valid/ready handshake.
- Loads the shift register and shifts one bit per enabled bit tick.
- Reports frame progress and completion.
- Sits between a word-producing block (e.g. a FIFO) and any serial output stage paced by a baud/bit-rate tick.

Parameters:
N, 8, data word width in bits (N >= 2)
CW, $clog2(N+1), bit-index counter width (derived; covers the optional parity slot)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
in_data  in  N  parallel word to serialize
in_valid  in  1  producer has a word on in_data
in_ready  out  1  controller accepts in_data this cycle
bit_tick  in  1  shift enable; current bit advances only on cycles where bit_tick=1
so  out  1  serial output bit
so_valid  out  1  so carries a frame bit
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final bit of a frame completes
bit_idx  out  CW  index of the bit currently on so (0 = LSB)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, shift register=0, bit_idx=0, so=0, so_valid=0, busy=0, done=0.
- Reset in mid-frame aborts the frame. The next cycle shows reset values, with in_ready=1 once reset deasserts. No done pulse is issued for an aborted frame.
- States:
  - IDLE: in_ready=1, so=0, so_valid=0.
  - SHIFT: a frame is on the line.
- Accept: a word is taken at a rising edge where in_valid && in_ready.
  - The shift register loads in_data.
  - bit_idx=0 and the state becomes SHIFT.
  - From the following cycle: so=in_data[0], so_valid=1, busy=1.
- SHIFT, bit_tick=0: so, bit_idx and the register hold, regardless of how long the gap is.
- SHIFT, bit_tick=1, not the last bit: the next edge right-shifts the register (MSB filled with 0) and increments bit_idx.
- Last bit: bit_idx=N-1, or bit_idx=N when PARITY_EN is defined.
  - in_ready = (state==IDLE) || (state==SHIFT && last bit && bit_tick). This is the only combinational path from an input to in_ready.
  - On the tick edge, done=1 for the following cycle.
  - If in_valid was also high, the new word loads and the next frame starts with zero gap: so=new[0], so_valid stays 1, busy stays 1.
  - Otherwise the state returns to IDLE and so_valid=0, busy=0 (done=1 in that same cycle).
- Frame length: exactly N bit periods, or N+1 with PARITY_EN. A bit period is the number of cycles until a bit_tick occurs in SHIFT.
- in_valid while in SHIFT and not at the last-bit tick: in_ready=0. The word is not taken, and the producer must hold it.
- bit_tick in IDLE is ignored.
- Latency: accept edge to first bit on so = 1 cycle.

Optional Feature:
Macro: SERIAL_TX_PARITY_EN
- Defined:
  - An even-parity bit (XOR of all N data bits) is transmitted after bit N-1, with bit_idx=N.
  - Parity is computed and registered at accept.
  - done follows the parity bit's tick.
- Undefined:
  - No parity logic or parity register.
  - The frame ends after bit N-1.
  - bit_idx never exceeds N-1.

Decomposition:
- Package serial_tx_pkg holds:
  - state encoding: IDLE=1'b0, SHIFT=1'b1
  - a CW width helper function
  - the frame-length constant selected by SERIAL_TX_PARITY_EN
- One sub-module, piso_shift_reg: an N-bit parallel-load, right-shift register with a synchronous active-high reset, a load input and a shift enable.
- The controller owns the FSM, bit counter, parity and handshake.

Test Plan:
1. N=8, bit_tick=1 constantly, accept 0xA5 -> so over 8 consecutive cycles = 1,0,1,0,0,1,0,1; bit_idx 0..7; done=1 in cycle 9; busy=0 at the same time.
2. bit_tick pulsed every 4th cycle, accept 0x3C -> each bit held exactly 4 cycles; sequence 0,0,1,1,1,1,0,0; no change on non-tick cycles.
3. in_valid held high with 0x01 then 0xFF -> second word is accepted on the last-bit tick edge of the first; so runs 1,0,0,0,0,0,0,0 then 1 x8 with so_valid never dropping; one done pulse per frame.
4. in_valid=1 with 0x55 during bit 3 of a frame -> in_ready=0 until the last-bit tick; 0x55 is serialized only after the current frame.
5. reset=1 for one cycle at bit_idx=3 -> next cycle so=0, so_valid=0, busy=0, bit_idx=0, no done pulse; in_ready=1.
6. SERIAL_TX_PARITY_EN defined, accept 0x07 -> 9 bits: 1,1,1,0,0,0,0,0 then parity 1; bit_idx reaches 8; done after the 9th tick.
